// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit ARM-style words and writes them to consecutive program-memory addresses.
// One word every two cycles: the word is registered on accept and written during the following cycle.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic              i_bit,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic              p,
    input  logic              u,
    input  logic              b,
    input  logic              w,
    input  logic              l,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       operand2,
    input  logic [11:0]       offset_std,
    input  logic [23:0]       offset_branch,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   instr_count,
    output logic              full,
    output logic              err
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              take_word;
    logic              take_illegal;
    logic [31:0]       word;

    assign full        = (count_q == COUNT_MAX);
    assign mem_addr    = addr_q;
    assign instr_count = count_q;
    assign mem_wdata   = wdata_q;
    assign err         = err_q;

    // Field packing by instruction class; bits [31:26] are common to all classes.
    always_comb begin
        word = '0;
        case (op)
            2'b00:   word = {cond, 2'b00, i_bit, opcode, s_bit, rn, rd, operand2};
            2'b01:   word = {cond, 2'b01, i_bit, p, u, b, w, l, rn, rd, offset_std};
            2'b10:   word = {cond, 2'b10, 1'b1, l, offset_branch};
            default: word = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        take_word    = 1'b0;
        take_illegal = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !full && !clear;
                if (in_valid && in_ready) begin
                    if (op == 2'b11) begin
                        take_illegal = 1'b1;
                    end else begin
                        take_word = 1'b1;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                // A clear arriving during the write cycle cancels the write outright.
                mem_we  = !clear;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (clear) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= take_illegal;
            if (take_word) begin
                wdata_q <= word;
            end
            if (mem_we) begin
                count_q <= count_q + COUNT_ONE;
                // Address parks on the last slot; full then blocks further accepts.
                if (addr_q != ADDR_LAST) begin
                    addr_q <= addr_q + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: reference vectors, hand-written corner sequences and a randomized run checked against a behavioural model.
module tb_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic        i_bit;
        logic [3:0]  opcode;
        logic        s_bit;
        logic        p;
        logic        u;
        logic        b;
        logic        w;
        logic        l;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] operand2;
        logic [11:0] offset_std;
        logic [23:0] offset_branch;
    } bundle_t;

    typedef struct packed {
        bundle_t     bun;
        logic [31:0] word;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    bundle_t           bun;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   instr_count;
    logic              full;
    logic              err;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .cond(bun.cond), .op(bun.op), .i_bit(bun.i_bit), .opcode(bun.opcode), .s_bit(bun.s_bit),
        .p(bun.p), .u(bun.u), .b(bun.b), .w(bun.w), .l(bun.l), .rn(bun.rn), .rd(bun.rd),
        .operand2(bun.operand2), .offset_std(bun.offset_std), .offset_branch(bun.offset_branch),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .instr_count(instr_count), .full(full), .err(err)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          m_count;
    bit          m_pending;
    bit          m_err;
    logic [31:0] m_word;
    bit          last_acc;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_pack(bundle_t x);
        logic [31:0] r;
        r = (32'(x.cond) << 28) | (32'(x.op) << 26);
        case (x.op)
            2'd0: r = r | (32'(x.i_bit) << 25) | (32'(x.opcode) << 21) | (32'(x.s_bit) << 20)
                        | (32'(x.rn) << 16) | (32'(x.rd) << 12) | 32'(x.operand2);
            2'd1: r = r | (32'(x.i_bit) << 25) | (32'(x.p) << 24) | (32'(x.u) << 23)
                        | (32'(x.b) << 22) | (32'(x.w) << 21) | (32'(x.l) << 20)
                        | (32'(x.rn) << 16) | (32'(x.rd) << 12) | 32'(x.offset_std);
            2'd2: r = r | (32'd1 << 25) | (32'(x.l) << 24) | 32'(x.offset_branch);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic bundle_t mk(logic [3:0] cnd, logic [1:0] o, logic i, logic [3:0] opc, logic s,
                                   logic pp, logic uu, logic bb, logic ww, logic ll,
                                   logic [3:0] n, logic [3:0] d, logic [11:0] op2,
                                   logic [11:0] offs, logic [23:0] offb);
        bundle_t x;
        x.cond = cnd; x.op = o; x.i_bit = i; x.opcode = opc; x.s_bit = s;
        x.p = pp; x.u = uu; x.b = bb; x.w = ww; x.l = ll; x.rn = n; x.rd = d;
        x.operand2 = op2; x.offset_std = offs; x.offset_branch = offb;
        return x;
    endfunction

    function automatic bundle_t rand_bun();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[$bits(bundle_t)-1:0];
    endfunction

    task automatic model_reset();
        m_count = 0; m_pending = 0; m_err = 0; m_word = 32'd0;
    endtask

    task automatic check_outputs();
        bit e_full;
        bit e_rdy;
        int e_addr;
        e_full = (m_count == DEPTH);
        e_rdy  = !m_pending && !e_full && !clear;
        e_addr = e_full ? DEPTH - 1 : m_count;
        chk("in_ready", in_ready, e_rdy);
        chk("mem_we", mem_we, m_pending && !clear);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, m_word);
        chk("instr_count", instr_count, m_count);
        chk("full", full, e_full);
        chk("err", err, m_err);
        last_acc = in_valid && e_rdy;
    endtask

    task automatic model_update(bit acc, bit clr, bundle_t x);
        if (clr) begin
            m_count = 0; m_pending = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_pending) begin
                m_count++;
                m_pending = 0;
            end else if (acc) begin
                if (x.op == 2'b11) m_err = 1;
                else begin
                    m_pending = 1;
                    m_word = ref_pack(x);
                end
            end
        end
    endtask

    // Called in the low clock phase with inputs already driven; ends at the next falling edge.
    task automatic step();
        bit      clr;
        bundle_t x;
        #1;
        check_outputs();
        clr = clear;
        x = bun;
        @(posedge clk);
        model_update(last_acc, clr, x);
        @(negedge clk);
    endtask

    task automatic send(bundle_t x, output bit ok);
        bun = x; in_valid = 1'b1; ok = 1'b0;
        for (int k = 0; k < 6 && !ok; k++) begin
            step();
            ok = last_acc;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t    tbl[6];
        bundle_t dp, mem, br, ill;
        bit      ok;
        int      acc_n;

        dp  = mk(4'hE, 2'b00, 1'b1, 4'h4, 1'b0, 0, 0, 0, 0, 0, 4'h1, 4'h2, 12'h005, 12'h000, 24'h0);
        mem = mk(4'hE, 2'b01, 1'b0, 4'h0, 1'b0, 1, 1, 0, 0, 1, 4'h1, 4'h0, 12'h000, 12'h004, 24'h0);
        br  = mk(4'hE, 2'b10, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000, 12'h000, 24'hFFFFFE);
        ill = mk(4'hE, 2'b11, 1'b1, 4'h4, 1'b1, 1, 1, 1, 1, 1, 4'h5, 4'h6, 12'h777, 12'h888, 24'h999999);

        tbl[0] = '{bun: dp,  word: 32'hE2812005};
        tbl[1] = '{bun: mem, word: 32'hE5910004};
        tbl[2] = '{bun: br,  word: 32'hEAFFFFFE};
        tbl[3] = '{bun: mk(4'h0, 2'b10, 1'b1, 4'hF, 1'b1, 1, 1, 1, 1, 1, 4'hF, 4'hF, 12'hFFF, 12'hFFF, 24'h123456),
                   word: 32'h0B123456};
        tbl[4] = '{bun: mk(4'h1, 2'b00, 1'b0, 4'hF, 1'b1, 1, 0, 1, 0, 1, 4'hA, 4'hB, 12'hFFF, 12'hABC, 24'hDEAD00),
                   word: 32'h11FABFFF};
        tbl[5] = '{bun: mk(4'h2, 2'b01, 1'b1, 4'h9, 1'b1, 0, 1, 1, 1, 0, 4'h3, 4'h4, 12'h123, 12'hFFF, 24'hBEEF00),
                   word: 32'h26E34FFF};

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; bun = '0; last_acc = 1'b0;
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step();

        // DP then MEM words land at consecutive addresses
        send(dp, ok);
        chk("dp_acc", ok, 1);
        #1;
        chk("dp_we", mem_we, 1);
        chk("dp_addr", mem_addr, 0);
        chk("dp_word", mem_wdata, 32'hE2812005);
        step();
        send(mem, ok);
        chk("mem_acc", ok, 1);
        #1;
        chk("mem_addr", mem_addr, 1);
        chk("mem_word", mem_wdata, 32'hE5910004);
        step();
        #1;
        chk("mem_count", instr_count, 2);

        // Branch with in_valid held: one accept every other cycle
        do_clear();
        bun = br; in_valid = 1'b1; acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            acc_n += int'(last_acc);
        end
        in_valid = 1'b0;
        chk("br_accepts", acc_n, 3);
        #1;
        chk("br_count", instr_count, 3);
        chk("br_word", mem_wdata, 32'hEAFFFFFE);

        // Illegal class: single err pulse, nothing written
        do_clear();
        send(ill, ok);
        chk("ill_acc", ok, 1);
        #1;
        chk("ill_err", err, 1);
        chk("ill_we", mem_we, 0);
        step();
        #1;
        chk("ill_err_drop", err, 0);
        chk("ill_count", instr_count, 0);

        // Fill to DEPTH; the extra bundle must be refused
        do_clear();
        for (int k = 0; k < 5; k++) begin
            send(tbl[k].bun, ok);
            chk($sformatf("fill_acc%0d", k), ok, k < DEPTH);
        end
        #1;
        chk("fill_full", full, 1);
        chk("fill_rdy", in_ready, 0);
        chk("fill_addr", mem_addr, DEPTH - 1);
        chk("fill_count", instr_count, DEPTH);
        do_clear();
        #1;
        chk("clr_full", full, 0);
        send(dp, ok);
        #1;
        chk("refill_we", mem_we, 1);
        chk("refill_addr", mem_addr, 0);
        step();

        // clear during the write cycle aborts it
        send(mem, ok);
        clear = 1'b1;
        #1;
        chk("abort_we", mem_we, 0);
        step();
        clear = 1'b0;
        #1;
        chk("abort_count", instr_count, 0);
        chk("abort_addr", mem_addr, 0);

        // Asynchronous reset in the middle of a write
        send(br, ok);
        #1;
        chk("arst_pre_we", mem_we, 1);
        rst = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_count", instr_count, 0);
        chk("arst_full", full, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Reference vectors
        for (int i = 0; i < 6; i++) begin
            do_clear();
            send(tbl[i].bun, ok);
            chk($sformatf("tbl%0d_acc", i), ok, 1);
            #1;
            chk($sformatf("tbl%0d_we", i), mem_we, 1);
            chk($sformatf("tbl%0d_word", i), mem_wdata, tbl[i].word);
            step();
        end

        // Randomized traffic against the model
        last_acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                bun = rand_bun();
            end
            clear = ($urandom_range(0, 24) == 0) || ((m_count == DEPTH) && ($urandom_range(0, 3) == 0));
            step();
        end
        clear = 1'b0;
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
